// File: rtl/ofdm_subcarrier_sched.sv
// Buffers 48 mapped QPSK symbols, then drains 64 IFFT bins in natural order with
// DC/guard nulls and four scrambled BPSK pilots inserted.
module ofdm_subcarrier_sched (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_axis_tvalid,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tlast,
  input  logic        s_bit_symb_last,
  output logic        s_axis_tready,
  output logic        m_axis_tvalid,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tlast,
  output logic        m_pkt_last,
  input  logic        m_axis_tready,
  output logic        sym_err
);

  localparam int unsigned NData   = 48;
  localparam logic [15:0] PilotRe = 16'h5A82;
  localparam logic [15:0] PilotNe = (~PilotRe) + 16'd1;
  localparam logic [6:0]  LfsrSeed = 7'h7F;

  typedef enum logic [0:0] {StFill, StDrain} state_e;

  state_e state_q, state_d;

  logic [5:0]  wr_idx_q;
  logic [5:0]  bin_q;
  logic        loaded_all_q;
  logic        pkt_flag_q;
  logic [6:0]  lfsr_q;
  logic        sym_err_q;
  logic        m_valid_q;
  logic [31:0] m_data_q;
  logic        m_last_q;
  logic        m_pkt_last_q;
  logic [31:0] buf_q [NData];

  logic        accept;
  logic        sym_done;
  logic        out_free;
  logic        load_en;
  logic        lfsr_out;
  logic [5:0]  rd_idx;
  logic        is_data;
  logic        is_pilot;
  logic        pilot_neg;
  logic [31:0] bin_data;

  assign accept   = s_axis_tvalid & s_axis_tready;
  assign sym_done = (state_q == StDrain) & m_valid_q & m_axis_tready & m_last_q;
  assign out_free = ~m_valid_q | m_axis_tready;
  assign load_en  = (state_q == StDrain) & out_free & ~loaded_all_q;
  assign lfsr_out = lfsr_q[6] ^ lfsr_q[3];

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= StFill;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFill:  if (accept && (wr_idx_q == 6'd47)) state_d = StDrain;
      StDrain: if (sym_done) state_d = StFill;
      default: state_d = StFill;
    endcase
  end

  // Output logic
  always_comb begin
    s_axis_tready = (state_q == StFill);
  end

  // Bin n -> subcarrier k = n (1..26) or n-64 (38..63); data index folds out the pilots.
  always_comb begin
    is_data   = 1'b0;
    is_pilot  = 1'b0;
    pilot_neg = lfsr_out;
    rd_idx    = 6'd0;
    if (bin_q inside {[6'd1:6'd6]}) begin
      is_data = 1'b1;
      rd_idx  = bin_q + 6'd23;
    end else if (bin_q inside {[6'd8:6'd20]}) begin
      is_data = 1'b1;
      rd_idx  = bin_q + 6'd22;
    end else if (bin_q inside {[6'd22:6'd26]}) begin
      is_data = 1'b1;
      rd_idx  = bin_q + 6'd21;
    end else if (bin_q inside {[6'd38:6'd42]}) begin
      is_data = 1'b1;
      rd_idx  = bin_q - 6'd38;
    end else if (bin_q inside {[6'd44:6'd56]}) begin
      is_data = 1'b1;
      rd_idx  = bin_q - 6'd39;
    end else if (bin_q inside {[6'd58:6'd63]}) begin
      is_data = 1'b1;
      rd_idx  = bin_q - 6'd40;
    end else if (bin_q inside {6'd7, 6'd43, 6'd57}) begin
      is_pilot = 1'b1;
    end else if (bin_q == 6'd21) begin
      is_pilot  = 1'b1;
      pilot_neg = ~lfsr_out;
    end
  end

  always_comb begin
    bin_data = 32'd0;
    if (is_data)       bin_data = buf_q[rd_idx];
    else if (is_pilot) bin_data = {16'd0, pilot_neg ? PilotNe : PilotRe};
  end

  // Symbol buffer is deliberately left uninitialised by reset.
  always_ff @(posedge clk) begin
    if (accept) buf_q[wr_idx_q] <= s_axis_tdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_idx_q     <= 6'd0;
      bin_q        <= 6'd0;
      loaded_all_q <= 1'b0;
      pkt_flag_q   <= 1'b0;
      lfsr_q       <= LfsrSeed;
      sym_err_q    <= 1'b0;
      m_valid_q    <= 1'b0;
      m_data_q     <= 32'd0;
      m_last_q     <= 1'b0;
      m_pkt_last_q <= 1'b0;
    end else begin
      if (accept) begin
        wr_idx_q <= wr_idx_q + 6'd1;
        if (s_axis_tlast) pkt_flag_q <= 1'b1;
        if (s_bit_symb_last != (wr_idx_q == 6'd47)) sym_err_q <= 1'b1;
      end

      if (load_en) begin
        bin_q        <= bin_q + 6'd1;
        loaded_all_q <= (bin_q == 6'd63);
        m_valid_q    <= 1'b1;
        m_data_q     <= bin_data;
        m_last_q     <= (bin_q == 6'd63);
        m_pkt_last_q <= (bin_q == 6'd63) & pkt_flag_q;
      end else if (out_free) begin
        m_valid_q    <= 1'b0;
        m_last_q     <= 1'b0;
        m_pkt_last_q <= 1'b0;
      end

      if (sym_done) begin
        wr_idx_q     <= 6'd0;
        pkt_flag_q   <= 1'b0;
        loaded_all_q <= 1'b0;
        lfsr_q       <= pkt_flag_q ? LfsrSeed : {lfsr_q[5:0], lfsr_out};
      end
    end
  end

  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tdata  = m_data_q;
  assign m_axis_tlast  = m_last_q;
  assign m_pkt_last    = m_pkt_last_q;
  assign sym_err       = sym_err_q;

endmodule

// File: tb/tb_ofdm_subcarrier_sched.sv
// Directed bench for ofdm_subcarrier_sched: reference bin mapper and pilot scrambler
// feed an expected-bin queue that the output monitor drains.
module tb_ofdm_subcarrier_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_axis_tvalid;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tlast;
  logic        s_bit_symb_last;
  logic        s_axis_tready;
  logic        m_axis_tvalid;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tlast;
  logic        m_pkt_last;
  logic        m_axis_tready;
  logic        sym_err;

  always #5 clk = ~clk;

  ofdm_subcarrier_sched dut (
    .clk             (clk),
    .rst             (rst),
    .s_axis_tvalid   (s_axis_tvalid),
    .s_axis_tdata    (s_axis_tdata),
    .s_axis_tlast    (s_axis_tlast),
    .s_bit_symb_last (s_bit_symb_last),
    .s_axis_tready   (s_axis_tready),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tlast    (m_axis_tlast),
    .m_pkt_last      (m_pkt_last),
    .m_axis_tready   (m_axis_tready),
    .sym_err         (sym_err)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic        pkt_last;
  } exp_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  exp_t        exp_q[$];
  logic [6:0]  m_lfsr;
  logic [31:0] sym_data [48];
  int          bins_seen = 0;
  int          tready_mode = 0;
  bit          held_v = 1'b0;
  logic [31:0] held_data;
  logic        held_last;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference mapping written in subcarrier terms k = -26..+26.
  function automatic logic [31:0] exp_bin(input int n, input bit p_neg);
    int k;
    k = (n < 32) ? n : n - 64;
    if (n == 0 || (n >= 27 && n <= 37)) return 32'd0;
    if (k == -21 || k == -7 || k == 7) return {16'd0, p_neg ? 16'hA57E : 16'h5A82};
    if (k == 21) return {16'd0, p_neg ? 16'h5A82 : 16'hA57E};
    if (k <= -22) return sym_data[k + 26];
    if (k <= -8)  return sym_data[k + 25];
    if (k <= -1)  return sym_data[k + 24];
    if (k <= 6)   return sym_data[k + 23];
    if (k <= 20)  return sym_data[k + 22];
    return sym_data[k + 21];
  endfunction

  initial begin
    int cyc;
    cyc = 0;
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      m_axis_tready = (tready_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
    end
  end

  // Output monitor, sampled on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && m_axis_tvalid) begin
        check("in_ready_in_drain", {31'd0, s_axis_tready}, 32'd0);
        if (held_v) begin
          check("stall_data_stable", m_axis_tdata, held_data);
          check("stall_last_stable", {31'd0, m_axis_tlast}, {31'd0, held_last});
        end
        if (m_axis_tready) begin
          held_v = 1'b0;
          if (exp_q.size() == 0) begin
            check("unexpected_bin", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check($sformatf("bin%0d_data", bins_seen % 64), m_axis_tdata, e.data);
            check($sformatf("bin%0d_last", bins_seen % 64), {31'd0, m_axis_tlast},
                  {31'd0, e.last});
            check($sformatf("bin%0d_pkt", bins_seen % 64), {31'd0, m_pkt_last},
                  {31'd0, e.pkt_last});
          end
          bins_seen++;
        end else begin
          held_v    = 1'b1;
          held_data = m_axis_tdata;
          held_last = m_axis_tlast;
        end
      end
    end
  end

  task automatic feed_symbol(input int gap_max, input bit pkt_end, input int bad_idx,
                             input bit rnd);
    bit ok;
    int t;
    bit p_neg;
    for (int i = 0; i < 48; i++) sym_data[i] = rnd ? $urandom : i;
    for (int i = 0; i < 48; i++) begin
      for (int g = 0; g < ((gap_max > 0) ? (i % (gap_max + 1)) : 0); g++) begin
        s_axis_tvalid = 1'b0;
        @(posedge clk);
        #1;
      end
      s_axis_tvalid   = 1'b1;
      s_axis_tdata    = sym_data[i];
      s_axis_tlast    = pkt_end && (i == 47);
      s_bit_symb_last = (i == 47) || (i == bad_idx);
      t = 0;
      do begin
        @(negedge clk);
        ok = s_axis_tready;
        @(posedge clk);
        #1;
        t++;
      end while (!ok && t < 500);
      check("accept_in_time", {31'd0, ok}, 32'd1);
    end
    s_axis_tvalid   = 1'b0;
    s_axis_tlast    = 1'b0;
    s_bit_symb_last = 1'b0;
    p_neg = m_lfsr[6] ^ m_lfsr[3];
    for (int n = 0; n < 64; n++) exp_q.push_back({exp_bin(n, p_neg), n == 63, pkt_end && n == 63});
    m_lfsr = pkt_end ? 7'h7F : {m_lfsr[5:0], p_neg};
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(posedge clk);
      t++;
    end
    #1;
    check("drain_done", exp_q.size(), 0);
    check("fill_ready_after", {31'd0, s_axis_tready}, 32'd1);
    check("out_idle_after", {31'd0, m_axis_tvalid}, 32'd0);
  endtask

  initial begin
    int t;
    int base;
    rst             = 1'b0;
    s_axis_tvalid   = 1'b0;
    s_axis_tdata    = 32'd0;
    s_axis_tlast    = 1'b0;
    s_bit_symb_last = 1'b0;
    m_lfsr          = 7'h7F;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, s_axis_tready}, 32'd1);
    check("rst_out_valid", {31'd0, m_axis_tvalid}, 32'd0);
    check("rst_out_data", m_axis_tdata, 32'd0);
    check("rst_out_last", {31'd0, m_axis_tlast}, 32'd0);
    check("rst_pkt_last", {31'd0, m_pkt_last}, 32'd0);
    check("rst_sym_err", {31'd0, sym_err}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // T1: ramp data, first bin one cycle after entering drain
    feed_symbol(0, 1'b0, -1, 1'b0);
    check("t1_ready_drop", {31'd0, s_axis_tready}, 32'd0);
    check("t1_no_bin_yet", {31'd0, m_axis_tvalid}, 32'd0);
    @(posedge clk);
    #1;
    check("t1_first_bin", {31'd0, m_axis_tvalid}, 32'd1);
    wait_drain();
    check("t1_sym_err", {31'd0, sym_err}, 32'd0);

    // T2: downstream stalls
    tready_mode = 1;
    feed_symbol(0, 1'b0, -1, 1'b0);
    wait_drain();
    tready_mode = 0;

    // T3: polarity sequence, packet end on third symbol, reseed on fourth
    feed_symbol(0, 1'b0, -1, 1'b1);
    wait_drain();
    feed_symbol(0, 1'b0, -1, 1'b1);
    wait_drain();
    feed_symbol(0, 1'b1, -1, 1'b1);
    wait_drain();
    feed_symbol(0, 1'b0, -1, 1'b1);
    wait_drain();
    check("t3_no_err", {31'd0, sym_err}, 32'd0);

    // T4: misplaced symbol marker
    feed_symbol(0, 1'b0, 30, 1'b1);
    wait_drain();
    check("t4_err_set", {31'd0, sym_err}, 32'd1);
    feed_symbol(0, 1'b0, -1, 1'b1);
    wait_drain();
    check("t4_err_sticky", {31'd0, sym_err}, 32'd1);

    // T5: reset at bin 20 of drain
    base = bins_seen;
    feed_symbol(0, 1'b0, -1, 1'b1);
    t = 0;
    while (bins_seen < base + 20 && t < 500) begin
      @(posedge clk);
      t++;
    end
    #1;
    check("t5_reached_bin20", bins_seen - base, 20);
    rst = 1'b0;
    #1;
    check("t5_valid_async_drop", {31'd0, m_axis_tvalid}, 32'd0);
    check("t5_ready_in_rst", {31'd0, s_axis_tready}, 32'd1);
    check("t5_err_cleared", {31'd0, sym_err}, 32'd0);
    exp_q.delete();
    held_v = 1'b0;
    m_lfsr = 7'h7F;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("t5_ready_after", {31'd0, s_axis_tready}, 32'd1);
    feed_symbol(0, 1'b0, -1, 1'b1);
    wait_drain();

    // T6: input gaps of 0..3 cycles
    feed_symbol(3, 1'b0, -1, 1'b0);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
